// File: rtl/mem_responder.sv
// mem_responder: single-ported functional data memory with a fixed-latency,
// strictly in-order response queue and request backpressure.
module mem_responder #(
    parameter int unsigned p_opaq_bits  = 8,
    parameter int unsigned p_num_words  = 256,
    parameter int unsigned p_latency    = 1,
    parameter int unsigned p_resp_depth = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [1:0]             req_msg_op,
    input  logic [p_opaq_bits-1:0] req_msg_opaque,
    input  logic [31:0]            req_msg_addr,
    input  logic [3:0]             req_msg_strb,
    input  logic [31:0]            req_msg_data,

    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [1:0]             resp_msg_op,
    output logic [p_opaq_bits-1:0] resp_msg_opaque,
    output logic [31:0]            resp_msg_addr,
    output logic [3:0]             resp_msg_strb,
    output logic [31:0]            resp_msg_data
);

    typedef enum logic [1:0] {
        MEM_MSG_READ  = 2'd0,
        MEM_MSG_WRITE = 2'd1
    } mem_op_e;

    localparam int unsigned AW = $clog2(p_num_words);
    localparam int unsigned PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int unsigned CW = $clog2(p_resp_depth + 1);
    localparam int unsigned GW = $clog2(p_latency + 1);

    localparam logic [CW-1:0] DEPTH = CW'(p_resp_depth);
    localparam logic [GW-1:0] LAT   = GW'(p_latency);
    localparam logic [PW-1:0] LAST  = PW'(p_resp_depth - 1);

    typedef struct packed {
        logic [1:0]             op;
        logic [p_opaq_bits-1:0] opaque;
        logic [31:0]            addr;
        logic [3:0]             strb;
        logic [31:0]            data;
    } msg_t;

    // Storage (never reset)
    logic [31:0] mem_q [p_num_words];
    logic [31:0] mem_word_d;
    logic [31:0] rd_word;
    logic [AW-1:0] widx;
    logic        is_write;
    logic        mem_we;

    // Response queue
    msg_t                    ent_msg_q [p_resp_depth];
    msg_t                    new_msg_d;
    msg_t                    head_msg;
    msg_t                    out_msg;
    logic [GW-1:0]           ent_age_q [p_resp_depth];
    logic [GW-1:0]           ent_age_d [p_resp_depth];
    logic [p_resp_depth-1:0] ent_vld_q, ent_vld_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic req_xfer;
    logic resp_xfer;

    // Request side: decode, backpressure, byte-merge for writes, response capture
    always_comb begin
        widx     = req_msg_addr[AW+1:2];
        rd_word  = mem_q[widx];
        is_write = (req_msg_op == MEM_MSG_WRITE);
        req_rdy  = (cnt_q < DEPTH);
        req_xfer = req_val & req_rdy;
        mem_we   = req_xfer & is_write & rst_n;
        for (int unsigned b = 0; b < 4; b++) begin
            mem_word_d[8*b +: 8] = req_msg_strb[b] ? req_msg_data[8*b +: 8]
                                                   : rd_word[8*b +: 8];
        end
        new_msg_d.op     = req_msg_op;
        new_msg_d.opaque = req_msg_opaque;
        new_msg_d.addr   = req_msg_addr;
        new_msg_d.strb   = req_msg_strb;
        new_msg_d.data   = is_write ? '0 : rd_word;
    end

    // Response side: head is presented only once it has aged to the full latency
    always_comb begin
        head_msg        = ent_msg_q[rd_ptr_q];
        resp_val        = ent_vld_q[rd_ptr_q] && (ent_age_q[rd_ptr_q] == LAT);
        resp_xfer       = resp_val & resp_rdy;
        out_msg         = resp_val ? head_msg : '0;
        resp_msg_op     = out_msg.op;
        resp_msg_opaque = out_msg.opaque;
        resp_msg_addr   = out_msg.addr;
        resp_msg_strb   = out_msg.strb;
        resp_msg_data   = out_msg.data;
    end

    // Queue next state: age every live entry (saturating), push/pop, count
    always_comb begin
        ent_vld_d = ent_vld_q;
        ent_age_d = ent_age_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        for (int unsigned i = 0; i < p_resp_depth; i++) begin
            if (ent_vld_q[i] && (ent_age_q[i] != LAT)) begin
                ent_age_d[i] = ent_age_q[i] + GW'(1);
            end
        end

        if (resp_xfer) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end

        // A full queue blocks requests, so the push slot never equals a popped head
        if (req_xfer) begin
            ent_vld_d[wr_ptr_q] = 1'b1;
            ent_age_d[wr_ptr_q] = GW'(1);
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end

        case ({req_xfer, resp_xfer})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Queue control state, cleared asynchronously so pending responses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < p_resp_depth; i++) begin
                ent_age_q[i] <= '0;
            end
        end else begin
            ent_vld_q <= ent_vld_d;
            ent_age_q <= ent_age_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Response payload captured at acceptance; gated by valid bits, so no reset
    always_ff @(posedge clk) begin
        if (req_xfer) begin
            ent_msg_q[wr_ptr_q] <= new_msg_d;
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[widx] <= mem_word_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a time-based
// reference model (expected-response queue stamped with acceptance cycle).
module tb_mem_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_val;
    logic        req_rdy;
    logic [1:0]  req_msg_op;
    logic [7:0]  req_msg_opaque;
    logic [31:0] req_msg_addr;
    logic [3:0]  req_msg_strb;
    logic [31:0] req_msg_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [1:0]  resp_msg_op;
    logic [7:0]  resp_msg_opaque;
    logic [31:0] resp_msg_addr;
    logic [3:0]  resp_msg_strb;
    logic [31:0] resp_msg_data;

    mem_responder #(
        .p_opaq_bits (8),
        .p_num_words (256),
        .p_latency   (LAT),
        .p_resp_depth(DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_val        (req_val),
        .req_rdy        (req_rdy),
        .req_msg_op     (req_msg_op),
        .req_msg_opaque (req_msg_opaque),
        .req_msg_addr   (req_msg_addr),
        .req_msg_strb   (req_msg_strb),
        .req_msg_data   (req_msg_data),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .resp_msg_op    (resp_msg_op),
        .resp_msg_opaque(resp_msg_opaque),
        .resp_msg_addr  (resp_msg_addr),
        .resp_msg_strb  (resp_msg_strb),
        .resp_msg_data  (resp_msg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  oq;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [256];
    int          n    = 0;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs vs model, clock edge, update model
    task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] oq,
                       input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic rr);
        exp_t e;
        logic acc, racc, ev;
        logic [7:0] idx;
        req_val        = v;
        req_msg_op     = op;
        req_msg_opaque = oq;
        req_msg_addr   = a;
        req_msg_strb   = s;
        req_msg_data   = d;
        resp_rdy       = rr;
        #1;
        ev = (q.size() > 0) && (n >= q[0].t + LAT - 1);
        chk("req_rdy", 128'(req_rdy), 128'(q.size() < DEPTH));
        chk("resp_val", 128'(resp_val), 128'(ev));
        if (ev) begin
            chk("resp_op",     128'(resp_msg_op),     128'(q[0].op));
            chk("resp_opaque", 128'(resp_msg_opaque), 128'(q[0].oq));
            chk("resp_addr",   128'(resp_msg_addr),   128'(q[0].a));
            chk("resp_strb",   128'(resp_msg_strb),   128'(q[0].s));
            chk("resp_data",   128'(resp_msg_data),   128'(q[0].d));
        end
        acc  = v && (q.size() < DEPTH);
        racc = ev && rr;
        @(posedge clk);
        n++;
        if (racc) void'(q.pop_front());
        if (acc) begin
            idx  = a[9:2];
            e.op = op; e.oq = oq; e.a = a; e.s = s; e.t = n;
            if (op == 2'd1) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
                e.d = 32'h0;
            end else begin
                e.d = mm[idx];
            end
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 2'd0, 8'd0, 32'd0, 4'd0, 32'd0, rr);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) idle(1'b1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_resp_val", 128'(resp_val), 128'd0);
        chk("rst_req_rdy",  128'(req_rdy),  128'd1);
        chk("rst_resp_msg",
            128'({resp_msg_op, resp_msg_opaque, resp_msg_addr, resp_msg_strb, resp_msg_data}),
            128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_val = 1'b0; req_msg_op = '0; req_msg_opaque = '0; req_msg_addr = '0;
        req_msg_strb = '0; req_msg_data = '0; resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;

        // Fill every word so later reads are fully defined (sustained throughput)
        for (int w = 0; w < 256; w++)
            cyc(1'b1, 2'd1, 8'(w), 32'(w * 4), 4'hF, $urandom, 1'b1);
        drain();

        // Basic write/read
        cyc(1'b1, 2'd1, 8'hA1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
        cyc(1'b1, 2'd0, 8'hA2, 32'h10, 4'hF, 32'h0, 1'b1);
        drain();

        // Byte strobes; strb ignored on read
        cyc(1'b1, 2'd1, 8'h01, 32'h20, 4'b1111, 32'h11223344, 1'b1);
        cyc(1'b1, 2'd1, 8'h02, 32'h20, 4'b0010, 32'h0000AA00, 1'b1);
        cyc(1'b1, 2'd0, 8'h03, 32'h20, 4'b1111, 32'h0, 1'b1);
        cyc(1'b1, 2'd0, 8'h04, 32'h22, 4'b0011, 32'h0, 1'b1);
        drain();

        // Latency: four back-to-back reads, opaques 0..3
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 2'd0, 8'(i), 32'(i * 4), 4'hF, 32'h0, 1'b1);
        drain();

        // Backpressure: six reads presented with resp_rdy low, four accepted
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 2'd0, 8'(8'h10 + i), 32'(32'h100 + i * 4), 4'hF, 32'h0, 1'b0);
        repeat (3) idle(1'b0);
        idle(1'b1);
        cyc(1'b1, 2'd0, 8'h15, 32'h114, 4'hF, 32'h0, 1'b0);
        repeat (2) idle(1'b0);
        drain();

        // Capture-at-accept with aliased write (0x440 aliases word 16)
        cyc(1'b1, 2'd0, 8'h30, 32'h40, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 2'd1, 8'h31, 32'h440, 4'hF, 32'h5, 1'b0);
        repeat (4) idle(1'b0);
        drain();
        cyc(1'b1, 2'd0, 8'h32, 32'h40, 4'hF, 32'h0, 1'b1);
        drain();

        // Randomized traffic, including unknown op codes
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), $urandom,
                4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
        drain();

        // Reset mid-operation with three outstanding requests
        cyc(1'b1, 2'd1, 8'h40, 32'h80, 4'hF, 32'hCAFEF00D, 1'b0);
        cyc(1'b1, 2'd0, 8'h41, 32'h10, 4'hF, 32'h0, 1'b0);
        cyc(1'b1, 2'd0, 8'h42, 32'h20, 4'hF, 32'h0, 1'b0);
        repeat (2) idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        q.delete();
        @(posedge clk);
        n++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) idle(1'b1);
        cyc(1'b1, 2'd0, 8'h50, 32'h80, 4'hF, 32'h0, 1'b1);
        cyc(1'b1, 2'd0, 8'h51, 32'h10, 4'hF, 32'h0, 1'b1);
        cyc(1'b1, 2'd0, 8'h52, 32'h20, 4'hF, 32'h0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
